// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the staggered reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StHold,
    StStretch,
    StRelease,
    StRun
  } state_e;

  // Register width able to hold values 0..n-1, never narrower than 1 bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Release synchroniser for the raw reset pin: clears asynchronously, shifts in 1s on release.
module reset_sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic synced_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign synced_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: asynchronous assertion, stretched and staggered synchronous
// release, software reset request and reset-cause flag.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_pin_n,
  input  logic                sw_reset_req,
  output logic [CHANNELS-1:0] areset,
  output logic                ready,
  output logic                reset_cause
);

  localparam int unsigned CntW = min1_clog2(max_u(STRETCH_CYCLES, STAGGER_CYCLES));
  localparam int unsigned IdxW = min1_clog2(CHANNELS);

  localparam logic [CntW-1:0] StretchLoad = CntW'(STRETCH_CYCLES - 1);
  localparam logic [CntW-1:0] StaggerLoad = CntW'(STAGGER_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx     = IdxW'(CHANNELS - 1);
  localparam logic [IdxW-1:0] FirstIdx    = IdxW'(1);

  if (SYNC_STAGES < 2) begin : gen_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (STRETCH_CYCLES < 1) begin : gen_bad_stretch
    $error("reset_sequencer: STRETCH_CYCLES must be >= 1");
  end
  if (CHANNELS < 1) begin : gen_bad_channels
    $error("reset_sequencer: CHANNELS must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : gen_bad_stagger
    $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
  end

  logic synced;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk),
    .rst_ni  (reset_pin_n),
    .synced_o(synced)
  );

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CHANNELS-1:0] areset_q, areset_d;
  logic                ready_q, ready_d;
  logic                cause_q, cause_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    areset_d = areset_q;
    ready_d  = ready_q;
    cause_d  = cause_q;

    // A software request is only honoured once the pin release has left HOLD.
    if (state_q != StHold && sw_reset_req) begin
      areset_d = '1;
      ready_d  = 1'b0;
      cause_d  = 1'b1;
      state_d  = StStretch;
      cnt_d    = StretchLoad;
      idx_d    = FirstIdx;
    end else begin
      unique case (state_q)
        StHold: begin
          if (synced) begin
            state_d = StStretch;
            cnt_d   = StretchLoad;
          end
        end
        StStretch: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else begin
            areset_d[0] = 1'b0;
            if (CHANNELS == 1) begin
              state_d = StRun;
              ready_d = 1'b1;
            end else begin
              state_d = StRelease;
              idx_d   = FirstIdx;
              cnt_d   = StaggerLoad;
            end
          end
        end
        StRelease: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
              if (IdxW'(k) == idx_q) areset_d[k] = 1'b0;
            end
            if (idx_q == LastIdx) begin
              state_d = StRun;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
              cnt_d = StaggerLoad;
            end
          end
        end
        StRun: begin
        end
        default: state_d = StHold;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_pin_n) begin
    if (!reset_pin_n) begin
      state_q  <= StHold;
      cnt_q    <= '0;
      idx_q    <= '0;
      areset_q <= '1;
      ready_q  <= 1'b0;
      cause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      areset_q <= areset_d;
      ready_q  <= ready_d;
      cause_q  <= cause_d;
    end
  end

  assign areset      = areset_q;
  assign ready       = ready_q;
  assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for two reset_sequencer configurations sharing the same pin and sw stimulus.
`timescale 1ns/100ps
module tb_reset_sequencer;

  localparam int ActNone    = 0;
  localparam int ActRelease = 1;
  localparam int ActPulse   = 2;
  localparam int ActAssert  = 3;

  logic       clk = 1'b0;
  logic       reset_pin_n = 1'b1;
  logic       sw_reset_req = 1'b0;
  logic [2:0] areset0;
  logic       ready0, cause0;
  logic [0:0] areset1;
  logic       ready1, cause1;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(2), .STRETCH_CYCLES(4), .CHANNELS(3), .STAGGER_CYCLES(3)
  ) dut0 (
    .clk(clk), .reset_pin_n(reset_pin_n), .sw_reset_req(sw_reset_req),
    .areset(areset0), .ready(ready0), .reset_cause(cause0)
  );

  reset_sequencer #(
    .SYNC_STAGES(3), .STRETCH_CYCLES(1), .CHANNELS(1), .STAGGER_CYCLES(1)
  ) dut1 (
    .clk(clk), .reset_pin_n(reset_pin_n), .sw_reset_req(sw_reset_req),
    .areset(areset1), .ready(ready1), .reset_cause(cause1)
  );

  // Reference model: each config remembers the edge its release sequence was anchored to.
  int ss[2] = '{2, 3};
  int st[2] = '{4, 1};
  int ch[2] = '{3, 1};
  int sg[2] = '{3, 1};
  int pin_edges[2];
  int anchor[2];
  int now[2];
  bit cause[2];

  typedef struct packed {
    logic [2:0] a0;
    logic       r0;
    logic       c0;
    logic       a1;
    logic       r1;
    logic       c1;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void model_pin_low(int d);
    pin_edges[d] = 0;
    anchor[d]    = -1;
    cause[d]     = 1'b0;
  endfunction

  function automatic void model_edge(int d, bit pin, bit sw);
    if (!pin) return;
    now[d]++;
    pin_edges[d]++;
    if (pin_edges[d] == ss[d] + 1) begin
      anchor[d] = now[d];
    end else if (pin_edges[d] > ss[d] + 1 && sw) begin
      anchor[d] = now[d];
      cause[d]  = 1'b1;
    end
  endfunction

  function automatic bit released(int d, int k);
    return anchor[d] >= 0 && (now[d] - anchor[d]) >= st[d] + k * sg[d];
  endfunction

  function automatic exp_t build_exp();
    exp_t e;
    for (int k = 0; k < 3; k++) e.a0[k] = !released(0, k);
    e.r0 = released(0, ch[0] - 1);
    e.c0 = cause[0];
    e.a1 = !released(1, 0);
    e.r1 = released(1, ch[1] - 1);
    e.c1 = cause[1];
    return e;
  endfunction

  // One clock of stimulus: model the edge, set sw for the next edge, optionally move the pin.
  task automatic step(input bit sw, input int act);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, reset_pin_n, sw_reset_req);
    #1;
    sw_reset_req = sw;
    #3.5;
    if (act == ActPulse || act == ActAssert) begin
      reset_pin_n = 1'b0;
      for (int d = 0; d < 2; d++) model_pin_low(d);
    end
    exp_q.push_back(build_exp());
    #1;
    if (act == ActPulse || act == ActRelease) reset_pin_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ActNone);
  endtask

  // Monitor: the outputs are registered, so sample every falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({areset0, ready0, cause0} !== {e.a0, e.r0, e.c0}) begin
          miscompares++;
          $display("FAIL cfg0 t=%0t areset=%b ready=%b cause=%b, expected areset=%b ready=%b cause=%b",
                   $time, areset0, ready0, cause0, e.a0, e.r0, e.c0);
        end
        vectors++;
        if ({areset1, ready1, cause1} !== {e.a1, e.r1, e.c1}) begin
          miscompares++;
          $display("FAIL cfg1 t=%0t areset=%b ready=%b cause=%b, expected areset=%b ready=%b cause=%b",
                   $time, areset1, ready1, cause1, e.a1, e.r1, e.c1);
        end
      end
    end
  end

  initial begin : driver
    int burst;
    for (int d = 0; d < 2; d++) begin
      now[d] = 0;
      model_pin_low(d);
    end
    #1;
    reset_pin_n = 1'b0;

    // Pin held, then released: full staggered sequence.
    idle(3);
    step(1'b0, ActRelease);
    idle(10);
    // Glitch on the pin late in the sequence, then a full rerun.
    step(1'b0, ActPulse);
    idle(16);
    // Single software request in RUN.
    step(1'b1, ActNone);
    idle(14);
    // Software request while channels are mid-release.
    step(1'b1, ActNone);
    idle(6);
    step(1'b1, ActNone);
    idle(14);
    // Request held for 10 edges.
    for (int i = 0; i < 10; i++) step(1'b1, ActNone);
    idle(15);
    // Request high during HOLD must be ignored.
    step(1'b1, ActPulse);
    step(1'b1, ActNone);
    step(1'b1, ActNone);
    idle(16);

    burst = 0;
    for (int i = 0; i < 500; i++) begin
      int r;
      bit sw;
      r = $urandom_range(0, 99);
      if (burst == 0 && r >= 96) burst = $urandom_range(2, 12);
      sw = (burst > 0) || ($urandom_range(0, 15) == 0);
      if (burst > 0) burst--;
      if (r < 2) step(sw, ActPulse);
      else if (r == 2) step(sw, ActAssert);
      else if (r == 3 && !reset_pin_n) step(sw, ActRelease);
      else step(sw, reset_pin_n ? ActNone : ActRelease);
    end
    idle(2);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
